// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam int ITER_STEPS = 32;
  localparam int CNT_W      = $clog2(ITER_STEPS);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Divide-by-zero: LO all ones, HI returns the original dividend.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Issue/result bundle between the EX stage and the HI/LO unit.
interface hilo_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_data, rt_data, cancel,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, rs_data, rt_data, cancel,
                  output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_iter_core.sv
// Iterative datapath: one shift-add (mul) or restoring shift-subtract (div) step per enable.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [63:0] acc
);
  logic [63:0] acc_q;
  logic [31:0] opnd;
  logic        div_q;
  logic [32:0] sum;
  logic [32:0] rem;
  logic [33:0] diff;

  // Partial remainder after the left shift can need 33 bits when the divisor is above 2^31.
  always_comb begin
    sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd};
    rem  = acc_q[63:31];
    diff = {1'b0, rem} - {2'b00, opnd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= {32'd0, opa};
      opnd  <= opb;
      div_q <= is_div;
    end else if (step) begin
      if (div_q) begin
        if (diff[33:32] == 2'b00) acc_q <= {diff[31:0], acc_q[30:0], 1'b1};
        else                      acc_q <= {rem[31:0],  acc_q[30:0], 1'b0};
      end else begin
        if (acc_q[0]) acc_q <= {sum, acc_q[31:1]};
        else          acc_q <= {1'b0, acc_q[63:1]};
      end
    end
  end

  assign acc = acc_q;
endmodule

// File: rtl/hilo_muldiv.sv
// MIPS HI/LO multiply/divide unit with sign fix-up and MTHI/MTLO.
// Optional HILO_FAST_MULT_EN: single-cycle MULT/MULTU, divides stay iterative.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  hilo_muldiv_if.slave bus
);
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q, a_raw;
  logic             done_q, sa_q, sb_q, div_q, div0_q;
  logic             sgn_op, arith, iter_ok, load;
  logic [63:0]      acc, prod;
  logic [31:0]      res_hi, res_lo;

  always_comb begin
    sgn_op = ~bus.op[0];
    arith  = ~bus.op[2];
`ifdef HILO_FAST_MULT_EN
    iter_ok = arith & bus.op[1];
`else
    iter_ok = arith;
`endif
    load = (state == ST_IDLE) && bus.start && !bus.cancel && iter_ok;
  end

  muldiv_iter_core u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (state == ST_RUN),
    .is_div (bus.op[1]),
    .opa    (mag32(bus.rs_data, sgn_op)),
    .opb    (mag32(bus.rt_data, sgn_op)),
    .acc    (acc)
  );

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    prod   = acc;
    if (div_q) begin
      if (div0_q) begin
        res_hi = a_raw;
        res_lo = DIV0_LO;
      end else begin
        res_lo = (sa_q ^ sb_q) ? -acc[31:0]  : acc[31:0];
        res_hi = sa_q          ? -acc[63:32] : acc[63:32];
      end
    end else begin
      prod = (sa_q ^ sb_q) ? -acc : acc;
      {res_hi, res_lo} = prod;
    end
  end

`ifdef HILO_FAST_MULT_EN
  logic [63:0] fast_mag, fast_p;
  always_comb begin
    fast_mag = {32'd0, mag32(bus.rs_data, sgn_op)} * {32'd0, mag32(bus.rt_data, sgn_op)};
    fast_p   = (sgn_op && (bus.rs_data[31] ^ bus.rt_data[31])) ? -fast_mag : fast_mag;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      div_q  <= 1'b0;
      div0_q <= 1'b0;
      a_raw  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.cancel) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (bus.start) begin
            if (iter_ok) begin
              state  <= ST_RUN;
              cnt    <= '0;
              sa_q   <= sgn_op & bus.rs_data[31];
              sb_q   <= sgn_op & bus.rt_data[31];
              div_q  <= bus.op[1];
              div0_q <= (bus.rt_data == 32'd0);
              a_raw  <= bus.rs_data;
            end
`ifdef HILO_FAST_MULT_EN
            else if (arith) begin
              {hi_q, lo_q} <= fast_p;
              done_q       <= 1'b1;
            end
`endif
            else if (bus.op == OP_MTHI) hi_q <= bus.rs_data;
            else if (bus.op == OP_MTLO) lo_q <= bus.rs_data;
          end
          ST_RUN: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER_STEPS - 1)) state <= ST_FIN;
          end
          ST_FIN: begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
